// File: rtl/riscv_pkg.sv
// riscv_pkg: shared funct3 encodings for loads/stores, the memory-stage FSM
// state type and the access legality check.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // True when the requested access must not reach the bus: simultaneous
  // load+store, reserved encodings, unsigned variants on a store, or a
  // halfword/word that is not naturally aligned.
  function automatic logic access_fault(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (rd && wr) begin
      bad = 1'b1;
    end else if (rd || wr) begin
      case (f3)
        F3_B:    bad = 1'b0;
        F3_H:    bad = off[0];
        F3_W:    bad = (off != 2'b00);
        F3_BU:   bad = wr;
        F3_HU:   bad = wr | off[0];
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/halfword lane out of a bus word
// and sign- or zero-extends it according to the load type.
module mem_load_align
  import riscv_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32
) (
  input  logic [WORD_BITWIDTH-1:0] rdata,
  input  logic [2:0]               funct3,
  input  logic [1:0]               byte_off,
  output logic [WORD_BITWIDTH-1:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select followed by extension; halfwords use only the upper offset bit.
  always_comb begin
    lane_b = rdata[{byte_off, 3'b000} +: 8];
    lane_h = rdata[{byte_off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = {{(WORD_BITWIDTH-8){lane_b[7]}}, lane_b};
      F3_BU:   load_data = {{(WORD_BITWIDTH-8){1'b0}}, lane_b};
      F3_H:    load_data = {{(WORD_BITWIDTH-16){lane_h[15]}}, lane_h};
      F3_HU:   load_data = {{(WORD_BITWIDTH-16){1'b0}}, lane_h};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage between the EX/MEM register and a valid/ready
// data bus. Legal accesses stall the pipeline until the bus completes;
// faulting accesses are flagged in the request cycle and never issued.
module mem_access
  import riscv_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic [2:0]               funct3,
  input  logic [WORD_BITWIDTH-1:0] addr,
  input  logic [WORD_BITWIDTH-1:0] storeData,
  output logic [WORD_BITWIDTH-1:0] memReadData,
  output logic                     stall,
  output logic                     memFault,
  output logic                     dmem_valid,
  output logic                     dmem_we,
  output logic [WORD_BITWIDTH-1:0] dmem_addr,
  output logic [3:0]               dmem_be,
  output logic [WORD_BITWIDTH-1:0] dmem_wdata,
  input  logic                     dmem_ready,
  input  logic [WORD_BITWIDTH-1:0] dmem_rdata
);

  mem_state_e               state_q;
  logic [WORD_BITWIDTH-1:0] rdata_q;
  logic                     we_q;
  logic [3:0]               be_q;
  logic [WORD_BITWIDTH-1:0] addr_q;
  logic [WORD_BITWIDTH-1:0] wdata_q;
  logic [2:0]               funct3_q;
  logic [1:0]               off_q;

  logic                     fault_c;
  logic                     access_c;
  logic [3:0]               be_c;
  logic [WORD_BITWIDTH-1:0] wdata_c;
  logic [WORD_BITWIDTH-1:0] load_data;

  // Legality is only meaningful while a new request can be accepted.
  always_comb begin
    fault_c  = (state_q == ST_IDLE) && access_fault(memRead, memWrite, funct3, addr[1:0]);
    access_c = (state_q == ST_IDLE) && (memRead ^ memWrite) && !fault_c;
  end

  // Byte enables and lane-replicated write data; loads read the whole word.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = storeData;
    if (memWrite) begin
      case (funct3)
        F3_B: begin
          be_c    = 4'b0001 << addr[1:0];
          wdata_c = WORD_BITWIDTH'({4{storeData[7:0]}});
        end
        F3_H: begin
          be_c    = 4'b0011 << addr[1:0];
          wdata_c = WORD_BITWIDTH'({2{storeData[15:0]}});
        end
        default: ;
      endcase
    end
  end

  mem_load_align #(
    .WORD_BITWIDTH(WORD_BITWIDTH)
  ) u_load_align (
    .rdata    (dmem_rdata),
    .funct3   (funct3_q),
    .byte_off (off_q),
    .load_data(load_data)
  );

  // Access FSM: latch the request on IDLE->BUSY, hold the bus until ready,
  // present the load result for one DONE cycle, then accept the next request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= F3_W;
      off_q    <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_c) begin
            state_q  <= ST_BUSY;
            we_q     <= memWrite;
            be_q     <= be_c;
            addr_q   <= {addr[WORD_BITWIDTH-1:2], 2'b00};
            wdata_q  <= wdata_c;
            funct3_q <= funct3;
            off_q    <= addr[1:0];
          end else if (fault_c) begin
            rdata_q <= '0;
          end
        end
        ST_BUSY: begin
          if (dmem_ready) begin
            state_q <= ST_DONE;
            if (!we_q) begin
              rdata_q <= load_data;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall       = access_c || (state_q == ST_BUSY);
  assign memFault    = fault_c;
  assign memReadData = fault_c ? '0 : rdata_q;
  assign dmem_valid  = (state_q == ST_BUSY);
  assign dmem_we     = we_q;
  assign dmem_be     = be_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven check of mem_access with a scoreboard queue,
// a bus responder with programmable ready delay, and hand-written reset and
// idle-ready sequences.
module tb_mem_access;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         memRead, memWrite;
  logic [2:0]   funct3;
  logic [W-1:0] addr, storeData;
  logic [W-1:0] memReadData;
  logic         stall, memFault;
  logic         dmem_valid, dmem_we;
  logic [W-1:0] dmem_addr;
  logic [3:0]   dmem_be;
  logic [W-1:0] dmem_wdata;
  logic         dmem_ready;
  logic [W-1:0] dmem_rdata;

  always #5 clk = ~clk;

  mem_access #(.WORD_BITWIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .addr       (addr),
    .storeData  (storeData),
    .memReadData(memReadData),
    .stall      (stall),
    .memFault   (memFault),
    .dmem_valid (dmem_valid),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          delay;
    logic        fault;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 18;
  vec_t tv [NV];
  vec_t sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    memRead   = 1'b0;
    memWrite  = 1'b0;
    funct3    = 3'b000;
    addr      = '0;
    storeData = '0;
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns the same way.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    int   stalls;
    memRead   = v.rd;
    memWrite  = v.wr;
    funct3    = v.f3;
    addr      = v.addr;
    storeData = v.sdata;
    sb_q.push_back(v);
    @(negedge clk);
    if (v.fault || !(v.rd || v.wr)) begin
      e = sb_q.pop_front();
      check({tag, " memFault"}, 32'(memFault), 32'(e.fault));
      check({tag, " stall"}, 32'(stall), 32'd0);
      check({tag, " valid"}, 32'(dmem_valid), 32'd0);
      if (e.fault) check({tag, " memReadData"}, memReadData, 32'd0);
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      check({tag, " valid_after"}, 32'(dmem_valid), 32'd0);
      @(posedge clk); #1;
      $display("txn %s: rd=%0b wr=%0b f3=%03b addr=0x%08h fault=%0b", tag, v.rd, v.wr, v.f3, v.addr, memFault);
      return;
    end
    check({tag, " memFault"}, 32'(memFault), 32'd0);
    check({tag, " stall_req"}, 32'(stall), 32'd1);
    stalls = stall ? 1 : 0;
    @(posedge clk); #1;
    // Pipeline inputs wander while BUSY; the DUT must ignore them.
    memRead   = 1'($urandom);
    memWrite  = 1'($urandom);
    funct3    = 3'($urandom);
    addr      = $urandom;
    storeData = $urandom;
    for (int k = 0; k <= v.delay; k++) begin
      dmem_ready = (k == v.delay);
      dmem_rdata = (k == v.delay) ? v.rdata : $urandom;
      @(negedge clk);
      if (stall) stalls++;
      check({tag, " busy_valid"}, 32'(dmem_valid), 32'd1);
      check({tag, " dmem_addr"}, dmem_addr, v.e_addr);
      check({tag, " dmem_be"}, 32'(dmem_be), 32'(v.e_be));
      check({tag, " dmem_we"}, 32'(dmem_we), 32'(v.wr));
      if (v.wr) check({tag, " dmem_wdata"}, dmem_wdata, v.e_wdata);
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
    dmem_rdata = $urandom;
    clear_inputs();
    @(negedge clk);
    if (stall) stalls++;
    e = sb_q.pop_front();
    check({tag, " done_valid"}, 32'(dmem_valid), 32'd0);
    check({tag, " memReadData"}, memReadData, e.e_rdata);
    check({tag, " stall_cycles"}, 32'(stalls), 32'(e.delay + 2));
    @(posedge clk); #1;
    $display("txn %s: rd=%0b wr=%0b f3=%03b addr=0x%08h data=0x%08h stalls=%0d", tag, v.rd, v.wr, v.f3, v.addr, memReadData, stalls);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t sw_v, lw_v;
    //          rd    wr    f3      addr       sdata         rdata          dly fault e_addr     e_be     e_wdata       e_rdata
    tv[0]  = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 0, 1'b0, 32'h104, 4'b1111, 32'h0,        32'hDEADBEEF};
    tv[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 2, 1'b0, 32'h100, 4'b1111, 32'h0,        32'hFFFFFF80};
    tv[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 2, 1'b0, 32'h100, 4'b1111, 32'h0,        32'h00000080};
    tv[3]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 1, 1'b0, 32'h100, 4'b1111, 32'h0,        32'hFFFF8001};
    tv[4]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h1234F00D, 0, 1'b0, 32'h100, 4'b1111, 32'h0,        32'h0000F00D};
    tv[5]  = '{1'b1, 1'b0, 3'b000, 32'h100, 32'h0,        32'hAABBCC7F, 0, 1'b0, 32'h100, 4'b1111, 32'h0,        32'h0000007F};
    tv[6]  = '{1'b1, 1'b0, 3'b001, 32'h106, 32'h0,        32'h7FFE0000, 0, 1'b0, 32'h104, 4'b1111, 32'h0,        32'h00007FFE};
    tv[7]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        1, 1'b0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h00007FFE};
    tv[8]  = '{1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        0, 1'b0, 32'h300, 4'b0010, 32'hA5A5A5A5, 32'h00007FFE};
    tv[9]  = '{1'b0, 1'b1, 3'b010, 32'h40C, 32'hCAFEF00D, 32'h0,        3, 1'b0, 32'h40C, 4'b1111, 32'hCAFEF00D, 32'h00007FFE};
    tv[10] = '{1'b0, 1'b1, 3'b000, 32'h303, 32'h12345666, 32'h0,        0, 1'b0, 32'h300, 4'b1000, 32'h66666666, 32'h00007FFE};
    tv[11] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    tv[12] = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    tv[13] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    tv[14] = '{1'b1, 1'b1, 3'b010, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    tv[15] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    tv[16] = '{1'b0, 1'b1, 3'b010, 32'h401, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    tv[17] = '{1'b0, 1'b0, 3'b010, 32'h100, 32'h0,        32'h0,        0, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0};

    rst        = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    clear_inputs();

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst memReadData", memReadData, 32'd0);
    check("rst valid", 32'(dmem_valid), 32'd0);
    check("rst we", 32'(dmem_we), 32'd0);
    check("rst be", 32'(dmem_be), 32'd0);
    check("rst addr", dmem_addr, 32'd0);
    check("rst wdata", dmem_wdata, 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_vec(tv[i], $sformatf("v%0d", i));
    end

    // Reset asserted while a load waits in BUSY.
    memRead = 1'b1;
    funct3  = 3'b010;
    addr    = 32'h104;
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("midrst busy_valid", 32'(dmem_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst valid", 32'(dmem_valid), 32'd0);
    check("midrst stall", 32'(stall), 32'd0);
    check("midrst be", 32'(dmem_be), 32'd0);
    check("midrst addr", dmem_addr, 32'd0);
    check("midrst memReadData", memReadData, 32'd0);
    $display("txn midrst: reset during BUSY, valid=%0b", dmem_valid);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Bus ready while idle must not start or complete anything.
    dmem_ready = 1'b1;
    dmem_rdata = 32'h55555555;
    @(negedge clk);
    check("idle_ready valid", 32'(dmem_valid), 32'd0);
    check("idle_ready stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    check("idle_ready memReadData", memReadData, 32'd0);
    $display("txn idle_ready: ready pulsed in IDLE, memReadData=0x%08h", memReadData);
    @(posedge clk); #1;

    // Store right after reset completes normally and leaves the cleared result.
    sw_v = '{1'b0, 1'b1, 3'b010, 32'h500, 32'h0BADF00D, 32'h0, 1, 1'b0, 32'h500, 4'b1111, 32'h0BADF00D, 32'h0};
    run_vec(sw_v, "post_rst_sw");
    lw_v = '{1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0BADF00D, 0, 1'b0, 32'h500, 4'b1111, 32'h0, 32'h0BADF00D};
    run_vec(lw_v, "post_rst_lw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter WORD_BITWIDTH, default 32, data and address width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 memRead  input  1  load request from EX/MEM register.
REQ-005 memWrite  input  1  store request from EX/MEM register.
REQ-006 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  WORD_BITWIDTH  byte address (ALU result).
REQ-008 storeData  input  WORD_BITWIDTH  rs2 value for stores.
REQ-009 memReadData  output  WORD_BITWIDTH  formatted load result, consumed by MEM/WB.
REQ-010 stall  output  1  freezes PC/IF/ID/EX/EX-MEM while high.
REQ-011 memFault  output  1  misaligned or illegal access.
REQ-012 dmem_valid  output  1  bus request valid.
REQ-013 dmem_we  output  1  bus write enable.
REQ-014 dmem_addr  output  WORD_BITWIDTH  word-aligned address (addr with [1:0]=00).
REQ-015 dmem_be  output  4  byte-lane enables.
REQ-016 dmem_wdata  output  WORD_BITWIDTH  lane-replicated store data.
REQ-017 dmem_ready  input  1  bus completion; read data valid this cycle.
REQ-018 dmem_rdata  input  WORD_BITWIDTH  bus read data.

Function
REQ-019 FSM states IDLE, BUSY, DONE; access = memRead XOR memWrite with no fault.
REQ-020 IDLE: access -> BUSY, stall=1; no access -> stay IDLE, stall=0.
REQ-021 BUSY: dmem_valid=1, stall=1, bus outputs from registers latched on IDLE->BUSY; stable until dmem_ready.
REQ-022 BUSY with dmem_ready=1 -> DONE; load result captured into memReadData register same edge.
REQ-023 DONE: stall=0, dmem_valid=0, memReadData held; unconditionally -> IDLE next cycle.
REQ-024 Minimum latency: 2 stall cycles (ready in first BUSY cycle); stall rises combinationally in the request cycle.
REQ-025 Fault: W with addr[1:0]!=00, H/HU with addr[0]=1, reserved funct3 (011,110,111; 100/101 on store), or memRead&memWrite -> memFault=1 combinationally in IDLE, no bus request, stall=0, memReadData=0.
REQ-026 Load format: select lane by addr[1:0]; B/H sign-extend from bit 7/15; BU/HU zero-extend; W passthrough.
REQ-027 Store: SB be=0001<<addr[1:0], wdata={4{d[7:0]}}; SH be=0011<<addr[1:0], wdata={2{d[15:0]}}; SW be=1111, wdata=d.
REQ-028 Loads drive dmem_we=0, dmem_be=1111.
REQ-029 Store completion in BUSY leaves memReadData unchanged.
REQ-030 Inputs changing during BUSY are ignored; transaction never aborted except by reset.
REQ-031 dmem_ready while not BUSY is ignored.

Reset
REQ-032 rst forces IDLE, memReadData=0, dmem_valid=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0 immediately, including mid-BUSY.
REQ-033 First cycle after rst release behaves as IDLE per REQ-020.

Structure
REQ-034 Shared package riscv_pkg holds funct3 load/store encodings and FSM state typedef.
REQ-035 Combinational sub-module mem_load_align performs lane select and extension (REQ-026).

Verification
REQ-036 LW addr=0x104, rdata=0xDEADBEEF, ready in 1st BUSY cycle -> stall high 2 cycles, memReadData=0xDEADBEEF in DONE.
REQ-037 LB addr=0x103, rdata=0x80112233, ready after 3 BUSY cycles -> 0xFFFFFF80, stall high 4 cycles; LBU same -> 0x00000080.
REQ-038 SH addr=0x202, storeData=0x1234ABCD -> dmem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1.
REQ-039 LW addr=0x102 -> memFault=1, stall=0, dmem_valid never asserted, memReadData=0.
REQ-040 rst asserted mid-BUSY -> dmem_valid low same cycle, IDLE after release; subsequent SW completes normally.
